// File: rtl/goertzel_pkg.sv
// Shared Q16.16 constants and FSM state encodings for the Goertzel controller.
package goertzel_pkg;

    localparam int unsigned Q_W      = 32;
    localparam int unsigned Q_INT_W  = 16;
    localparam int unsigned Q_FRAC_W = 16;
    localparam logic [Q_W-1:0] Q_ONE = 32'h0001_0000;

    localparam int unsigned ST_W = 4;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_MUL_CS  = 4'd1;
    localparam state_t ST_WAIT_CS = 4'd2;
    localparam state_t ST_ACC     = 4'd3;
    localparam state_t ST_P_S1SQ  = 4'd4;
    localparam state_t ST_P_S2SQ  = 4'd5;
    localparam state_t ST_P_CS1   = 4'd6;
    localparam state_t ST_P_CS1S2 = 4'd7;
    localparam state_t ST_OUT     = 4'd8;

endpackage

// File: rtl/mult_sign.sv
// Signed fixed-point multiplier: full-width product realigned to the output Q format.
// Operands are captured on en; c_out/valid follow two cycles later.
module mult_sign
    import goertzel_pkg::*;
#(
    parameter int unsigned DW     = Q_W,
    parameter int unsigned INT1_I = Q_INT_W,
    parameter int unsigned INT2_I = Q_INT_W,
    parameter int unsigned INT3_O = Q_INT_W
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] c_out,
    output logic          valid
);

    localparam int unsigned PW = 2 * DW;
    // Drop the surplus fraction bits so the result lands in the output format.
    localparam int unsigned SH = (DW - INT1_I) + (DW - INT2_I) - (DW - INT3_O);

    logic signed [PW-1:0] prod_r;
    logic                 prod_v;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod_r <= '0;
            prod_v <= 1'b0;
            c_out  <= '0;
            valid  <= 1'b0;
        end else begin
            prod_v <= en;
            if (en) begin
                prod_r <= PW'($signed(a_in)) * PW'($signed(b_in));
            end
            valid <= prod_v;
            if (prod_v) begin
                c_out <= DW'(prod_r >>> SH);
            end
        end
    end

endmodule

// File: rtl/goertzel_ctrl.sv
// Goertzel single-bin detector: runs the S1/S2 recurrence over N_SAMP samples,
// then computes |X|^2 through one shared multiplier.
module goertzel_ctrl
    import goertzel_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned N_SAMP = 205,
    parameter int unsigned CW     = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic [DW-1:0] coeff,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_power,
    output logic          busy
);

    state_t        state;
    state_t        state_nx;

    logic [DW-1:0] s1;
    logic [DW-1:0] s2;
    logic [DW-1:0] x;
    logic [DW-1:0] prod;
    logic [DW-1:0] pacc;
    logic [DW-1:0] cs1;
    logic [DW-1:0] coeff_reg;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    logic          iss;
    logic          mul_pend;
    logic          mul_en_c;
    logic [DW-1:0] mul_a_c;
    logic [DW-1:0] mul_b_c;
    logic [DW-1:0] mul_c;
    logic          mul_valid;

    assign cnt_inc = cnt + CW'(1);

    mult_sign #(
        .DW    (DW),
        .INT1_I(Q_INT_W),
        .INT2_I(Q_INT_W),
        .INT3_O(Q_INT_W)
    ) u_mult (
        .clk  (clk),
        .rstn (rstn),
        .en   (mul_en_c),
        .a_in (mul_a_c),
        .b_in (mul_b_c),
        .c_out(mul_c),
        .valid(mul_valid)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Never issue while a product is outstanding, so any valid seen in a wait
    // state belongs to the request made there (results orphaned by clr drain first).
    always_comb begin
        state_nx = state;
        mul_en_c = 1'b0;
        mul_a_c  = s1;
        mul_b_c  = s1;
        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) state_nx = ST_MUL_CS;
            end
            ST_MUL_CS: begin
                mul_a_c = coeff_reg;
                if (!mul_pend) begin
                    mul_en_c = 1'b1;
                    state_nx = ST_WAIT_CS;
                end
            end
            ST_WAIT_CS: begin
                mul_a_c = coeff_reg;
                if (mul_valid) state_nx = ST_ACC;
            end
            ST_ACC: begin
                state_nx = (cnt_inc == CW'(N_SAMP)) ? ST_P_S1SQ : ST_IDLE;
            end
            ST_P_S1SQ: begin
                mul_en_c = !iss && !mul_pend;
                if (iss && mul_valid) state_nx = ST_P_S2SQ;
            end
            ST_P_S2SQ: begin
                mul_a_c  = s2;
                mul_b_c  = s2;
                mul_en_c = !iss && !mul_pend;
                if (iss && mul_valid) state_nx = ST_P_CS1;
            end
            ST_P_CS1: begin
                mul_a_c  = coeff_reg;
                mul_en_c = !iss && !mul_pend;
                if (iss && mul_valid) state_nx = ST_P_CS1S2;
            end
            ST_P_CS1S2: begin
                mul_a_c  = cs1;
                mul_b_c  = s2;
                mul_en_c = !iss && !mul_pend;
                if (iss && mul_valid) state_nx = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (clr) begin
            state_nx = ST_IDLE;
            mul_en_c = 1'b0;
        end
    end

    // Multiplier bookkeeping: pend spans en..valid, iss marks "requested in this state".
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mul_pend <= 1'b0;
            iss      <= 1'b0;
        end else begin
            if (mul_en_c) begin
                mul_pend <= 1'b1;
            end else if (mul_valid) begin
                mul_pend <= 1'b0;
            end
            if (state_nx != state) begin
                iss <= 1'b0;
            end else if (mul_en_c) begin
                iss <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_power <= '0;
            s1        <= '0;
            s2        <= '0;
            x         <= '0;
            prod      <= '0;
            pacc      <= '0;
            cs1       <= '0;
            coeff_reg <= '0;
            cnt       <= '0;
        end else begin
            in_ready <= (state_nx == ST_IDLE);
            busy     <= (state_nx != ST_IDLE);
            if (clr) begin
                s1        <= '0;
                s2        <= '0;
                cnt       <= '0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (in_valid && in_ready) begin
                            x <= in_data;
                            if (cnt == '0) coeff_reg <= coeff;
                        end
                    end
                    ST_WAIT_CS: begin
                        if (mul_valid) prod <= mul_c;
                    end
                    ST_ACC: begin
                        s2  <= s1;
                        s1  <= x + prod - s2;
                        cnt <= cnt_inc;
                    end
                    ST_P_S1SQ: begin
                        if (iss && mul_valid) pacc <= mul_c;
                    end
                    ST_P_S2SQ: begin
                        if (iss && mul_valid) pacc <= pacc + mul_c;
                    end
                    ST_P_CS1: begin
                        if (iss && mul_valid) cs1 <= mul_c;
                    end
                    ST_P_CS1S2: begin
                        if (iss && mul_valid) begin
                            out_power <= pacc - mul_c;
                            out_valid <= 1'b1;
                        end
                    end
                    ST_OUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            s1        <= '0;
                            s2        <= '0;
                            cnt       <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_goertzel_ctrl.sv
// Bench for goertzel_ctrl: three instances (N_SAMP = 1, 2, 4) share the stimulus bus;
// results are compared with a plain-arithmetic Goertzel reference.
module tb_goertzel_ctrl;
    import goertzel_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clr;
    logic [31:0] coeff;
    logic [31:0] in_data;
    logic        out_ready;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        busy      [3];
    logic [31:0] out_power [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        goertzel_ctrl #(
            .DW    (32),
            .N_SAMP(g == 0 ? 1 : (g == 1 ? 2 : 4)),
            .CW    (16)
        ) u_dut (
            .clk      (clk),
            .rstn     (rstn),
            .clr      (clr),
            .coeff    (coeff),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data),
            .out_valid(out_valid[g]),
            .out_ready(out_ready),
            .out_power(out_power[g]),
            .busy     (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Q16.16 product, floor-rounded, wrapped to 32 bits.
    function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 32'(p >>> 16);
    endfunction

    function automatic logic [31:0] ref_power(input logic [31:0] c, input logic [31:0] xs[$]);
        logic [31:0] s1, s2, t;
        s1 = '0;
        s2 = '0;
        foreach (xs[i]) begin
            t  = xs[i] + qmul(c, s1) - s2;
            s2 = s1;
            s1 = t;
        end
        return qmul(s1, s1) + qmul(s2, s2) - qmul(qmul(c, s1), s2);
    endfunction

    task automatic send(input int sel, input logic [31:0] d, input logic [31:0] c);
        int k;
        k = 0;
        @(negedge clk);
        coeff         = c;
        in_data       = d;
        in_valid[sel] = 1'b1;
        while (!in_ready[sel] && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_wait", 32'(in_ready[sel]), 32'd1);
        @(posedge clk);
        #1 in_valid[sel] = 1'b0;
        @(negedge clk);
        check("busy_after_accept", 32'(busy[sel]), 32'd1);
        check("in_ready_after_accept", 32'(in_ready[sel]), 32'd0);
    endtask

    task automatic recv(input int sel, input logic [31:0] exp, input string tag, input int dly);
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid[sel] && k < 500) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_out_valid"}, 32'(out_valid[sel]), 32'd1);
        repeat (dly) @(negedge clk);
        check({tag, "_power"}, out_power[sel], exp);
        check({tag, "_in_ready_low"}, 32'(in_ready[sel]), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_out_valid_drop"}, 32'(out_valid[sel]), 32'd0);
        check({tag, "_idle"}, 32'(busy[sel]), 32'd0);
    endtask

    int          sel, n, k, dly, seen;
    logic [31:0] c0, d, exp_p;
    logic [31:0] xs[$];
    logic [31:0] held;

    initial begin
        rstn      = 1'b0;
        clr       = 1'b0;
        coeff     = '0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;

        #1;
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_out_power", out_power[0], 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready[0]), 32'd1);

        // N=1, coeff 1.0, x=3.0
        send(0, 32'h0003_0000, Q_ONE);
        recv(0, 32'h0009_0000, "n1", 0);

        // N=2, coeff 2.0, x=1.0 then 0; coeff changes on the second sample must not matter
        send(1, 32'h0001_0000, 32'h0002_0000);
        send(1, 32'h0000_0000, 32'h1234_5678);
        recv(1, 32'h0001_0000, "n2", 0);

        // N=4, coeff 0, four ones
        for (int i = 0; i < 4; i++) send(2, Q_ONE, 32'h0);
        recv(2, 32'h0000_0000, "n4", 0);

        // Backpressure: result must hold for 10 cycles
        send(0, 32'h0003_0000, Q_ONE);
        k = 0;
        @(negedge clk);
        while (!out_valid[0] && k < 500) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            check("hold_out_valid", 32'(out_valid[0]), 32'd1);
            check("hold_out_power", out_power[0], 32'h0009_0000);
            check("hold_in_ready", 32'(in_ready[0]), 32'd0);
            @(negedge clk);
        end
        recv(0, 32'h0009_0000, "hold_release", 0);

        // clr during the coeff*S1 finalise step
        send(0, 32'h0003_0000, Q_ONE);
        k = 0;
        while (g_dut[0].u_dut.state != ST_P_CS1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("reach_p_cs1", 32'(g_dut[0].u_dut.state == ST_P_CS1), 32'd1);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        check("clr_busy", 32'(busy[0]), 32'd0);
        check("clr_in_ready", 32'(in_ready[0]), 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        check("clr_no_out_valid", 32'(seen), 32'd0);
        send(0, 32'h0003_0000, Q_ONE);
        recv(0, 32'h0009_0000, "after_clr", 0);

        // clr in the same cycle as an input transfer drops the sample
        @(negedge clk);
        coeff       = Q_ONE;
        in_data     = 32'h0005_0000;
        in_valid[0] = 1'b1;
        clr         = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        clr         = 1'b0;
        check("clr_vs_input_busy", 32'(busy[0]), 32'd0);
        send(0, 32'h0002_0000, Q_ONE);
        recv(0, 32'h0004_0000, "clr_vs_input", 0);

        // Async reset while waiting on the recurrence product
        send(1, 32'h0007_0000, 32'h0003_0000);
        k = 0;
        while (g_dut[1].u_dut.state != ST_WAIT_CS && k < 50) begin
            @(negedge clk);
            k++;
        end
        #2 rstn = 1'b0;
        #1;
        check("arst_busy", 32'(busy[1]), 32'd0);
        check("arst_out_valid", 32'(out_valid[1]), 32'd0);
        check("arst_out_power", out_power[1], 32'h0);
        check("arst_in_ready", 32'(in_ready[1]), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        send(1, 32'h0001_0000, 32'h0002_0000);
        send(1, 32'h0000_0000, 32'h0002_0000);
        recv(1, 32'h0001_0000, "after_arst", 0);

        // Randomised blocks against the reference model
        for (int b = 0; b < 16; b++) begin
            sel = int'($urandom_range(0, 2));
            n   = (sel == 0) ? 1 : ((sel == 1) ? 2 : 4);
            c0  = 32'($urandom_range(0, 32'h0004_0000)) - 32'h0002_0000;
            xs.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) d = $urandom;
                else d = 32'($urandom_range(0, 32'h0002_0000)) - 32'h0001_0000;
                xs.push_back(d);
                send(sel, d, (i == 0) ? c0 : $urandom);
            end
            exp_p = ref_power(c0, xs);
            dly   = int'($urandom_range(0, 3));
            recv(sel, exp_p, "rand", dly);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/goertzel_ctrl.md
GOERTZEL_CTRL -- requirements
Module: goertzel_ctrl

Interface
REQ-001 Parameter DW, default 32: data width of samples, coefficient, state and power (all Q16.16 signed).
REQ-002 Parameter N_SAMP, default 205: samples per Goertzel block, legal range 1..65535.
REQ-003 Parameter CW, default 16: width of the internal sample counter.
REQ-004 Port: clk  input  1  system clock; all logic on rising edge.
REQ-005 Port: rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 Port: clr  input  1  synchronous abort of the current block.
REQ-007 Port: coeff  input  DW  2cos(w) in Q16.16, sampled on the first accepted sample of each block.
REQ-008 Port: in_valid / in_ready  input / output  1 / 1  sample handshake.
REQ-009 Port: in_data  input  DW  sample, Q16.16.
REQ-010 Port: out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-011 Port: out_power  output  DW  |X|^2 = S1*S1 + S2*S2 - coeff*S1*S2, Q16.16.
REQ-012 Port: busy  output  1  high in every state except IDLE.

Function
REQ-013 Block SHALL own exactly one mult_sign instance (DW, INT1_I=16, INT2_I=16, INT3_O=16) and use its c_out for every product.
REQ-014 Multiplier en SHALL be a single-cycle pulse with a_in/b_in held stable from the en cycle until multiplier valid; no fixed multiplier latency assumed.
REQ-015 States: IDLE, MUL_CS, WAIT_CS, ACC, P_S1SQ, P_S2SQ, P_CS1, P_CS1S2, OUT.
REQ-016 in_ready SHALL be high only in IDLE; a transfer (in_valid & in_ready) latches in_data into x, moves to MUL_CS.
REQ-017 MUL_CS: pulse en with (coeff_reg, S1) -> WAIT_CS; on valid -> ACC.
REQ-018 ACC (one cycle): S2 <= S1; S1 <= x + prod - S2; counter +1; if counter reaches N_SAMP -> P_S1SQ, else -> IDLE.
REQ-019 Finalise sequence: P_S1SQ S1*S1 -> P_S2SQ S2*S2 -> P_CS1 coeff*S1 -> P_CS1S2 (coeff*S1)*S2, each waiting on valid; power = sq1 + sq2 - cs1s2.
REQ-020 All adds/subtracts SHALL be DW-bit two's-complement, wrap-around, no saturation.
REQ-021 OUT: out_valid high, out_power stable until out_ready; on transfer, S1, S2, counter cleared -> IDLE.
REQ-022 out_valid and out_ready high in the same cycle SHALL complete the transfer in that cycle.
REQ-023 clr SHALL, in any state, clear S1, S2, counter, out_valid and return to IDLE next cycle; an in-flight multiplier result SHALL be ignored.
REQ-024 clr and an input transfer in the same cycle: clr wins, sample dropped.
REQ-025 coeff SHALL be captured only when counter == 0 at an accepted sample; later changes have no effect within the block.

Reset
REQ-026 rstn low SHALL asynchronously force: state IDLE, S1=S2=0, counter 0, coeff_reg 0, en 0, out_valid 0, out_power 0, busy 0; in_ready high after release.
REQ-027 Reset mid-block SHALL discard all partial state; the multiplier shares the same rstn.

Structure
REQ-028 State enum and Q16.16 constants (ONE = 0x0001_0000, INT/FRAC widths) SHALL live in shared package goertzel_pkg.
REQ-029 Sole sub-module: mult_sign; all sequencing, accumulation and handshakes in goertzel_ctrl.

Verification
REQ-030 N_SAMP=1, coeff=0x0001_0000, x=0x0003_0000 -> out_power=0x0009_0000.
REQ-031 N_SAMP=2, coeff=0x0002_0000, x=0x0001_0000 then 0 -> out_power=0x0001_0000.
REQ-032 N_SAMP=4, coeff=0, x=0x0001_0000 x4 -> out_power=0x0000_0000.
REQ-033 out_ready held low 10 cycles -> out_valid and out_power stable; in_ready low throughout.
REQ-034 clr pulsed during P_CS1 -> IDLE next cycle, out_valid never asserted; next block (REQ-030 stimulus) gives 0x0009_0000.
REQ-035 rstn asserted mid-WAIT_CS -> all outputs at reset values immediately; REQ-031 afterwards passes.
